// File: rtl/hap_scroller.sv
// Character-code source for the DE2 HAPPY display: a five-digit window into a fixed
// 8-slot message that auto-scrolls on a prescaled tick or single-steps from a key.
module hap_scroller #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       En,
  input  logic       Dir,
  input  logic       Step,
  output logic [2:0] C0,
  output logic [2:0] C1,
  output logic [2:0] C2,
  output logic [2:0] C3,
  output logic [2:0] C4,
  output logic [2:0] Pos,
  output logic       Tick
);

  localparam logic [25:0] CntLast = 26'(TICK_DIV - 1);

  function automatic logic [2:0] msg_char(input logic [2:0] idx);
    logic [2:0] code;
    unique case (idx)
      3'd0:    code = 3'b000;
      3'd1:    code = 3'b001;
      3'd2:    code = 3'b010;
      3'd3:    code = 3'b011;
      3'd4:    code = 3'b100;
      default: code = 3'b111;
    endcase
    return code;
  endfunction

  logic [25:0] cnt_q, cnt_d;
  logic [2:0]  pos_q, pos_d;
  logic        tick_q, tick_d;
  logic [1:0]  sync_q, sync_d;
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic        step_dly_q, step_dly_d;
  logic        step_dly_vld_q, step_dly_vld_d;
  logic        auto_tick;
  logic        step_pulse;
  logic        advance;

  // Valid bits ride alongside the synchronizer so a Step held through reset must
  // first be seen low before a rising edge can count.
  always_comb begin
    sync_d         = {sync_q[0], Step};
    sync_vld_d     = {sync_vld_q[0], 1'b1};
    step_dly_d     = sync_q[1];
    step_dly_vld_d = sync_vld_q[1];
    step_pulse     = sync_q[1] & sync_vld_q[1] & ~step_dly_q & step_dly_vld_q;
  end

  // RUN/PAUSE is the En level itself: auto-ticks only while En=1, steps only while En=0.
  always_comb begin
    auto_tick = En && (cnt_q == CntLast);
    advance   = auto_tick || (step_pulse && !En);

    cnt_d = cnt_q;
    if (En) begin
      cnt_d = auto_tick ? 26'd0 : cnt_q + 26'd1;
    end

    pos_d = pos_q;
    if (advance) begin
      pos_d = Dir ? pos_q - 3'd1 : pos_q + 3'd1;
    end
    tick_d = advance;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q          <= '0;
      pos_q          <= '0;
      tick_q         <= 1'b0;
      sync_q         <= '0;
      sync_vld_q     <= '0;
      step_dly_q     <= 1'b0;
      step_dly_vld_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pos_q          <= pos_d;
      tick_q         <= tick_d;
      sync_q         <= sync_d;
      sync_vld_q     <= sync_vld_d;
      step_dly_q     <= step_dly_d;
      step_dly_vld_q <= step_dly_vld_d;
    end
  end

  always_comb begin
    C0   = msg_char(pos_q);
    C1   = msg_char(pos_q + 3'd1);
    C2   = msg_char(pos_q + 3'd2);
    C3   = msg_char(pos_q + 3'd3);
    C4   = msg_char(pos_q + 3'd4);
    Pos  = pos_q;
    Tick = tick_q;
  end

endmodule

// File: tb/tb_hap_scroller.sv
// Directed bench for hap_scroller: one instance with TICK_DIV=4 and one with TICK_DIV=8
// share all inputs; checks reset, scrolling, wrap, pause, stepping and step rejection.
module tb_hap_scroller;

  localparam logic [14:0] Happy = 15'b000_001_010_011_100;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, step;
  logic [2:0] a_c0, a_c1, a_c2, a_c3, a_c4, a_pos;
  logic [2:0] b_c0, b_c1, b_c2, b_c3, b_c4, b_pos;
  logic       a_tick, b_tick;
  logic [14:0] a_word;
  int total = 0;
  int bad   = 0;
  int n;

  always #10 clk = ~clk;

  assign a_word = {a_c0, a_c1, a_c2, a_c3, a_c4};

  hap_scroller #(.TICK_DIV(4)) u_a (
    .CLOCK_50(clk), .Resetn(rst_n), .En(en), .Dir(dir), .Step(step),
    .C0(a_c0), .C1(a_c1), .C2(a_c2), .C3(a_c3), .C4(a_c4), .Pos(a_pos), .Tick(a_tick)
  );

  hap_scroller #(.TICK_DIV(8)) u_b (
    .CLOCK_50(clk), .Resetn(rst_n), .En(en), .Dir(dir), .Step(step),
    .C0(b_c0), .C1(b_c1), .C2(b_c2), .C3(b_c3), .C4(b_c4), .Pos(b_pos), .Tick(b_tick)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; dir = 1'b0; step = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pos", 16'(a_pos), 16'd0);
    chk("rst_tick", 16'(a_tick), 16'd0);
    chk("rst_word", 16'(a_word), 16'(Happy));

    // Auto left scroll through a full wrap
    cyc(2);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(3);
      chk("left_idle", 16'(a_tick), 16'd0);
      cyc(1);
      chk("left_tick", 16'(a_tick), 16'd1);
      chk("left_pos", 16'(a_pos), 16'(i % 8));
      if (i == 5) chk("left_win5", 16'(a_word), 16'(15'b111_111_111_000_001));
    end
    cyc(4);
    chk("pre_rst_pos", 16'(a_pos), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pos", 16'(a_pos), 16'd0);
    chk("async_rst_tick", 16'(a_tick), 16'd0);
    chk("async_rst_word", 16'(a_word), 16'(Happy));

    // Right scroll wraps 0 -> 7
    dir = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk("right_idle", 16'(a_tick), 16'd0);
    cyc(1);
    chk("right_tick", 16'(a_tick), 16'd1);
    chk("right_pos", 16'(a_pos), 16'd7);
    chk("right_word", 16'(a_word), 16'(15'b111_000_001_010_011));
    cyc(1);
    chk("tick_one_cycle", 16'(a_tick), 16'd0);

    // Pause with cnt=2, resume: tick two cycles later
    cyc(1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("pause_tick", 16'(a_tick), 16'd0);
    end
    chk("pause_pos", 16'(a_pos), 16'd7);
    en = 1'b1;
    cyc(1);
    chk("resume_idle", 16'(a_tick), 16'd0);
    cyc(1);
    chk("resume_tick", 16'(a_tick), 16'd1);
    chk("resume_pos", 16'(a_pos), 16'd6);

    // Single steps while paused
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; step = 1'b0;
    #1 rst_n = 1'b1;
    cyc(3);
    for (int p = 1; p <= 3; p++) begin
      step = 1'b1;
      cyc(2);
      chk("step_early_tick", 16'(a_tick), 16'd0);
      chk("step_early_pos", 16'(a_pos), 16'(p - 1));
      cyc(1);
      chk("step_tick", 16'(a_tick), 16'd1);
      chk("step_pos", 16'(a_pos), 16'(p));
      step = 1'b0;
      cyc(3);
      chk("step_after", 16'(a_tick), 16'd0);
    end

    // Held key advances once
    step = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (a_tick) n++;
    end
    chk("held_ticks", 16'(n), 16'd1);
    chk("held_pos", 16'(a_pos), 16'd4);
    step = 1'b0;
    cyc(3);

    // Key held through reset never produces a step
    step = 1'b1; rst_n = 1'b0;
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (a_tick) n++;
    end
    chk("rst_held_ticks", 16'(n), 16'd0);
    chk("rst_held_pos", 16'(a_pos), 16'd0);
    step = 1'b0;
    cyc(3);

    // Step discarded while running; TICK_DIV=8 instance ticks every 8 cycles
    rst_n = 1'b0; en = 1'b1; dir = 1'b0; step = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) step = 1'b1;
      if (k == 6) step = 1'b0;
      cyc(1);
      chk("run8_tick", 16'(b_tick), 16'(k == 8 || k == 16));
      if (k == 8) chk("run8_pos8", 16'(b_pos), 16'd1);
    end
    chk("run8_pos", 16'(b_pos), 16'd2);
    en = 1'b0;
    cyc(5);
    chk("run8_not_queued", 16'(b_pos), 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hap_scroller.md
# hap_scroller

Sequential character-code source that feeds the 3-bit HAPPY character decoders on the DE2 board. Holds the fixed 8-slot message "H A P P Y blank blank blank" and drives five 3-bit character codes, one per HEX digit, forming a five-character window into that message. The window rotates by one slot per prescaled tick, with run/pause, direction and single-step control from switches and keys. Each output code connects directly to one 3-bit character decoder input.

## Interface
- TICK_DIV, 50_000_000, CLOCK_50 cycles per scroll step; legal range 1..2^26.
- CLOCK_50  in  1  system clock, 50 MHz, all state on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- En  in  1  1 = auto-scroll, 0 = paused; level, synchronous to CLOCK_50.
- Dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset-1); level.
- Step  in  1  raw pushbutton level, active-high after board inversion; asynchronous, synchronized internally.
- C0..C4  out  3 each  character codes for digits HEX4..HEX0 (C0 leftmost); 000 H, 001 A, 010 P, 011 P, 100 Y, 111 blank.
- Pos  out  3  current window offset (0..7).
- Tick  out  1  one-cycle pulse on every offset change (auto or step).

## Operation
- Message ROM MSG[0..7] = 000, 001, 010, 011, 100, 111, 111, 111.
- Ci = MSG[(Pos + i) mod 8] for i = 0..4; combinational from Pos register only (no input-to-output paths).
- Prescaler: 26-bit counter cnt, counts 0..TICK_DIV-1 while En=1, wraps to 0; auto-tick when cnt = TICK_DIV-1 and En=1.
- En=0: cnt holds its value (not cleared); resumes from held value on re-enable.
- Step path: 2-flop synchronizer then rising-edge detector → step pulse (one cycle per press, no debounce; bench drives clean edges).
- Advance condition = auto-tick OR (step pulse AND En=0). Step pulses while En=1 are discarded, not queued.
- On advance: Pos ← Pos+1 mod 8 if Dir=0, Pos−1 mod 8 if Dir=1; Tick=1 that cycle (registered, asserted the cycle after the advancing edge, coincident with new Pos).
- Wrap-around: Pos 7 → 0 (left), 0 → 7 (right); modulo-8, no saturation.
- Dir change mid-count: does not reset cnt; takes effect at the next advance.
- State machine (2 states, encoded by En sampling): RUN (En=1, auto-tick advances) and PAUSE (En=0, only step advances); RUN→PAUSE when En=0, PAUSE→RUN when En=1, both on the next edge.
- TICK_DIV=1: auto-tick every cycle while En=1.

## Timing
- Reset (Resetn=0, asynchronous): Pos=0, cnt=0, Tick=0, synchronizer and edge flops=0; hence C0..C4 = 000,001,010,011,100 ("HAPPY").
- Reset deassertion: first advance no earlier than TICK_DIV cycles after first edge with Resetn=1 and En=1.
- Reset mid-count or mid-step: all state cleared immediately; a step press in flight is lost; Step held high through reset produces no pulse (edge detector starts at 0 but synchronizer must see a 0→1 after reset).
- Auto-tick latency: Pos/Tick change on the edge after cnt = TICK_DIV-1 is sampled, i.e. exactly TICK_DIV cycles between successive advances while En=1.
- Step latency: Pos changes 3 edges after Step rises (2 sync + 1 edge-detect/update).
- Simultaneous auto-tick and step pulse: impossible by definition (step ignored when En=1); exactly one advance.
- En falling on the same edge as cnt = TICK_DIV-1: the tick is taken (En sampled high on that edge).

## Test plan
- Reset: assert Resetn=0 mid-run → C0..C4 = 000,001,010,011,100, Pos=0, Tick=0 without a clock edge.
- Auto left scroll, TICK_DIV=4, En=1, Dir=0: Tick every 4 cycles; Pos 0→1→…→7→0; at Pos=5, C0..C4 = 111,111,111,000,001.
- Right scroll wrap, TICK_DIV=4, Dir=1 from reset: first advance Pos=7, C0..C4 = 111,000,001,010,011.
- Pause/resume: En=0 when cnt=2 for 10 cycles → no Tick, Pos held; En=1 → next Tick 2 cycles later (cnt resumes at 2).
- Single step: En=0, three clean Step presses → Pos 0→3, Tick pulses exactly 3 times, each 3 edges after its rising edge; Step held high 20 cycles → one advance only.
- Step ignored in RUN: En=1, TICK_DIV=8, press Step mid-count → Pos changes only on prescaler ticks, 8 cycles apart.
